sm_ram_arbiter: RTL and testbench
=================================

// Module: sm_ram_arbiter
// PURPOSE
//  Shares the single-port data RAM between NREQ requesters (req 0 = CPU load/store, req 1 = debug/loader).
//  Per-cycle arbitration, fixed-priority or round-robin, optional lock for atomic read-modify-write.
//  Sits between requesters and the RAM; RAM has a synchronous read with 1-cycle latency.
// PARAMETERS
//  NREQ        2    number of requesters (2..4)
//  ADDR_WIDTH  6    RAM word-address width
//  DATA_WIDTH  32   data word width
//  RR_MODE     1    1 = round-robin; 0 = fixed priority, lowest index wins
// PORTS
//  clk        in   1              clock, all logic on posedge
//  rst        in   1              synchronous reset, active-high
//  req        in   NREQ           request per requester; held until gnt
//  lock       in   NREQ           keep ownership after this access
//  we         in   NREQ           1 = write, 0 = read
//  addr       in   NREQ*AW        word address, requester i at [i*AW +: AW]
//  wdata      in   NREQ*DW        write data, requester i at [i*DW +: DW]
//  gnt        out  NREQ           one-hot, access accepted this cycle
//  rvalid     out  NREQ           one-hot, read data valid this cycle
//  rdata      out  DW             read data, shared, qualified by rvalid
//  ram_en     out  1              RAM access strobe
//  ram_we     out  1              RAM write enable
//  ram_addr   out  AW             RAM address
//  ram_wdata  out  DW             RAM write data
//  ram_rdata  in   DW             RAM read data, valid cycle after ram_en & ~ram_we
// BEHAVIOUR
//  Reset: gnt=0, rvalid=0, ram_en=0, ram_we=0, rr pointer=0, state=UNLOCKED, owner=0, rdata=0.
//  Arbitration (cycle t, combinational on registered state): candidates = req masked by state;
//   winner w -> gnt[w]=1, ram_en=1, ram_we=we[w], ram_addr/ram_wdata = slice w, all in cycle t.
//  No candidates -> gnt=0, ram_en=0, ram_we=0; ram_addr/ram_wdata hold last values.
//  Throughput: one access per cycle; back-to-back grants to the same requester allowed.
//  Read: rvalid[w]=1 and rdata=ram_rdata at t+1; writes never raise rvalid.
//  Requester contract: req/we/addr/wdata/lock stable until gnt; deasserting req without gnt is legal (withdraw).
//  RR_MODE=1: search starts at pointer p, wraps NREQ-1 -> 0; on grant p <= (w+1) mod NREQ.
//   No requester waits more than NREQ-1 grants while holding req (unlocked state).
//  RR_MODE=0: lowest asserted index wins; pointer unused, stays 0.
//  Lock FSM, states UNLOCKED, LOCKED:
//   UNLOCKED: grant with lock[w]=1 -> LOCKED, owner<=w.
//   LOCKED: candidates = req & (1<<owner); grant with lock[owner]=0 -> UNLOCKED (this access completes).
//   LOCKED, owner drops req: stays LOCKED, no grants; others starve by design.
//   Pointer not advanced while LOCKED; the unlocking grant advances it.
//  Simultaneous: read grant at t and new grant at t+1 -> rvalid for t and gnt for t+1 in same cycle.
//  Reset mid-operation: in-flight read suppressed (rvalid=0 in cycle after rst), lock released.
//  Addresses wrap naturally at 2^ADDR_WIDTH; no range check.
//  rvalid/rdata registered; gnt and ram_* combinational from req and registered state (no req->gnt loop through rvalid).
// STRUCTURE
//  sm_ram_arbiter.vh: `define ARB_UNLOCKED 1'b0, `ARB_LOCKED 1'b1, `ARB_MAXREQ 4.
//  Sub-module sm_rr_pick: combinational rotating one-hot picker (req, ptr, rr_en) -> (gnt_onehot, idx).
//  Top: state/owner/pointer registers, read-tag register (valid + idx), mux to RAM.
// TESTING
//  1 Reset: hold rst 3 cycles with req=2'b11 -> gnt=0, rvalid=0, ram_en=0 throughout.
//  2 Single read: req=01, we=0, addr0=5, RAM[5]=0xDEADBEEF -> gnt=01 at t, rvalid=01, rdata=0xDEADBEEF at t+1.
//  3 Contention RR: req=11 held 4 cycles -> gnt sequence 01,10,01,10; RR_MODE=0 -> 01,01,01,01.
//  4 Lock RMW: req0 lock=1 read addr 3, then write addr 3 lock=0 with req1 held -> gnt 01,01, then 10.
//  5 Write then read same addr: req0 write addr 7 data 0x12345678 at t, read addr 7 at t+1 -> rvalid 01 at t+2, rdata 0x12345678.
//  6 Reset mid-read: grant read at t, rst=1 at t+1 -> rvalid=0 at t+1, state UNLOCKED, pointer 0.

Source files
------------

// File: rtl/sm_ram_arbiter_pkg.sv
// Shared types and helpers for the data-RAM arbiter.
package sm_ram_arbiter_pkg;

  // Lock FSM: UNLOCKED arbitrates freely, LOCKED serves only the owner.
  typedef enum logic {
    ArbUnlocked = 1'b0,
    ArbLocked   = 1'b1
  } arbState_t;

  localparam int unsigned ArbMaxReq = 4;

  // Requester index width for 2..ArbMaxReq requesters.
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/sm_rr_pick.sv
// Combinational rotating one-hot picker: first asserted request at or after ptr,
// wrapping NREQ-1 -> 0. With rrEn low the search always starts at index 0.
module sm_rr_pick
  import sm_ram_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDXW = idxWidth(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  input  logic            rrEn,
  output logic [NREQ-1:0] gntOnehot,
  output logic [IDXW-1:0] idx
);

  logic            found;
  int unsigned     start;
  int unsigned     slot;
  logic [NREQ-1:0] reqBits;

  // Scan NREQ slots starting at the pointer and keep the first hit.
  always_comb begin
    gntOnehot = '0;
    idx       = '0;
    found     = 1'b0;
    slot      = 0;
    reqBits   = '0;
    start     = rrEn ? 32'(ptr) : 32'd0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      slot    = (start + k) % NREQ;
      reqBits = req >> slot;
      if (!found && reqBits[0]) begin
        found = 1'b1;
        idx   = IDXW'(slot);
      end
    end
    if (found) gntOnehot = NREQ'(1) << idx;
  end

endmodule

// File: rtl/sm_ram_arbiter.sv
// Single-port data RAM arbiter: per-cycle grant (round-robin or fixed priority),
// lock for atomic read-modify-write, and a read tag to route the 1-cycle read data.
module sm_ram_arbiter
  import sm_ram_arbiter_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          RR_MODE    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            lock,
  input  logic [NREQ-1:0]            we,
  input  logic [NREQ*ADDR_WIDTH-1:0] addr,
  input  logic [NREQ*DATA_WIDTH-1:0] wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [ADDR_WIDTH-1:0]      ram_addr,
  output logic [DATA_WIDTH-1:0]      ram_wdata,
  input  logic [DATA_WIDTH-1:0]      ram_rdata
);

  localparam int unsigned IdxW = idxWidth(NREQ);

  arbState_t             state;
  logic [IdxW-1:0]       owner;
  logic [IdxW-1:0]       ptr;
  logic                  rdValid;
  logic [IdxW-1:0]       rdIdx;
  logic [ADDR_WIDTH-1:0] addrHold;
  logic [DATA_WIDTH-1:0] wdataHold;

  logic [NREQ-1:0]       ownerMask;
  logic [NREQ-1:0]       cand;
  logic [NREQ-1:0]       pickGnt;
  logic [IdxW-1:0]       winIdx;
  logic [NREQ-1:0]       weBits;
  logic [NREQ-1:0]       lockBits;
  logic                  anyGnt;
  logic                  winWe;
  logic                  winLock;

  // Candidates: all requests when unlocked, only the owner when locked; none during reset.
  always_comb begin
    ownerMask = NREQ'(1) << owner;
    cand      = (state == ArbLocked) ? (req & ownerMask) : req;
    if (rst) cand = '0;
  end

  sm_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IdxW)
  ) u_pick (
    .req       (cand),
    .ptr       (ptr),
    .rrEn      (RR_MODE),
    .gntOnehot (pickGnt),
    .idx       (winIdx)
  );

  // Route the winner to the RAM; address/data hold their last value when idle.
  always_comb begin
    anyGnt    = |pickGnt;
    gnt       = pickGnt;
    weBits    = we >> winIdx;
    lockBits  = lock >> winIdx;
    winWe     = weBits[0];
    winLock   = lockBits[0];
    ram_en    = anyGnt;
    ram_we    = anyGnt & winWe;
    ram_addr  = anyGnt ? addr[winIdx*ADDR_WIDTH +: ADDR_WIDTH] : addrHold;
    ram_wdata = anyGnt ? wdata[winIdx*DATA_WIDTH +: DATA_WIDTH] : wdataHold;
  end

  // Read return; rst also masks the tag so a read in flight at reset never surfaces.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (rdValid && !rst) begin
      rvalid = NREQ'(1) << rdIdx;
      rdata  = ram_rdata;
    end
  end

  // Lock FSM, round-robin pointer, read tag and idle-hold registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ArbUnlocked;
      owner     <= '0;
      ptr       <= '0;
      rdValid   <= 1'b0;
      rdIdx     <= '0;
      addrHold  <= '0;
      wdataHold <= '0;
    end else begin
      rdValid <= anyGnt & ~winWe;
      if (anyGnt) begin
        rdIdx     <= winIdx;
        addrHold  <= ram_addr;
        wdataHold <= ram_wdata;
        unique case (state)
          ArbUnlocked: begin
            if (winLock) begin
              state <= ArbLocked;
              owner <= winIdx;
            end
          end
          ArbLocked: begin
            if (!winLock) state <= ArbUnlocked;
          end
          default: state <= ArbUnlocked;
        endcase
        // Grants that keep an existing lock leave the pointer alone.
        if (RR_MODE && (state == ArbUnlocked || !winLock)) begin
          ptr <= IdxW'((32'(winIdx) + 32'd1) % NREQ);
        end
      end
    end
  end

endmodule

// File: tb/tb_sm_ram_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter driven by the same stimulus,
// each with its own synchronous-read RAM model.
module tb_sm_ram_arbiter;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req, lock, we;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;

  logic [1:0]    gntR, rvalidR, gntF, rvalidF;
  logic [DW-1:0] rdataR, rdataF, ramWdataR, ramWdataF, ramRdataR, ramRdataF;
  logic          ramEnR, ramWeR, ramEnF, ramWeF;
  logic [AW-1:0] ramAddrR, ramAddrF;

  logic [DW-1:0] memR [64];
  logic [DW-1:0] memF [64];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sm_ram_arbiter #(.NREQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1'b1)) dutRr (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gntR), .rvalid(rvalidR), .rdata(rdataR), .ram_en(ramEnR), .ram_we(ramWeR),
    .ram_addr(ramAddrR), .ram_wdata(ramWdataR), .ram_rdata(ramRdataR)
  );

  sm_ram_arbiter #(.NREQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1'b0)) dutFp (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gntF), .rvalid(rvalidF), .rdata(rdataF), .ram_en(ramEnF), .ram_we(ramWeF),
    .ram_addr(ramAddrF), .ram_wdata(ramWdataF), .ram_rdata(ramRdataF)
  );

  always @(posedge clk) begin
    if (ramEnR) begin
      if (ramWeR) memR[ramAddrR] <= ramWdataR;
      else        ramRdataR <= memR[ramAddrR];
    end
    if (ramEnF) begin
      if (ramWeF) memF[ramAddrF] <= ramWdataF;
      else        ramRdataF <= memF[ramAddrF];
    end
  end

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    rst = 1'b1; req = 2'b00; lock = 2'b00; we = 2'b00;
    nextCycle();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 2'b11; lock = 2'b00; we = 2'b00; addr = '0; wdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (gntR !== 2'b00) $display("FAIL reset_gnt_rr[%0d]: got %b want 00", i, gntR); else passes++;
      checks++; if (gntF !== 2'b00) $display("FAIL reset_gnt_fp[%0d]: got %b want 00", i, gntF); else passes++;
      checks++; if (rvalidR !== 2'b00) $display("FAIL reset_rvalid[%0d]: got %b want 00", i, rvalidR); else passes++;
      checks++; if (ramEnR !== 1'b0) $display("FAIL reset_ram_en[%0d]: got %b want 0", i, ramEnR); else passes++;
    end
    checks++; if (rdataR !== 32'h0) $display("FAIL reset_rdata: got %h want 00000000", rdataR); else passes++;
    nextCycle();
    rst = 1'b0; req = 2'b00;
  endtask

  task automatic test_single_read;
    req = 2'b01; we = 2'b00; addr = {6'd0, 6'd5};
    @(negedge clk);
    checks++; if (gntR !== 2'b01) $display("FAIL read_gnt: got %b want 01", gntR); else passes++;
    checks++; if (ramEnR !== 1'b1 || ramWeR !== 1'b0 || ramAddrR !== 6'd5)
      $display("FAIL read_ram: got en=%b we=%b addr=%0d want en=1 we=0 addr=5", ramEnR, ramWeR, ramAddrR);
    else passes++;
    nextCycle();
    req = 2'b00;
    @(negedge clk);
    checks++; if (rvalidR !== 2'b01) $display("FAIL read_rvalid: got %b want 01", rvalidR); else passes++;
    checks++; if (rdataR !== 32'hDEADBEEF) $display("FAIL read_rdata: got %h want deadbeef", rdataR); else passes++;
    checks++; if (gntR !== 2'b00) $display("FAIL read_idle_gnt: got %b want 00", gntR); else passes++;
    nextCycle();
  endtask

  task automatic test_contention;
    logic [1:0] expR [4];
    expR = '{2'b01, 2'b10, 2'b01, 2'b10};
    doReset();
    req = 2'b11; we = 2'b00; addr = {6'd1, 6'd0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (gntR !== expR[i]) $display("FAIL rr_gnt[%0d]: got %b want %b", i, gntR, expR[i]); else passes++;
      checks++; if (gntF !== 2'b01) $display("FAIL fp_gnt[%0d]: got %b want 01", i, gntF); else passes++;
      nextCycle();
    end
    req = 2'b00;
  endtask

  task automatic test_lock_rmw;
    doReset();
    req = 2'b11; lock = 2'b01; we = 2'b00; addr = {6'd9, 6'd3}; wdata = '0;
    @(negedge clk);
    checks++; if (gntR !== 2'b01) $display("FAIL rmw_read_gnt: got %b want 01", gntR); else passes++;
    nextCycle();
    lock = 2'b00; we = 2'b01; wdata = {32'h0, 32'hCAFE0003};
    @(negedge clk);
    checks++; if (gntR !== 2'b01) $display("FAIL rmw_write_gnt: got %b want 01", gntR); else passes++;
    checks++; if (rvalidR !== 2'b01 || rdataR !== 32'hA5A50003)
      $display("FAIL rmw_rdata: got rvalid=%b data=%h want 01 a5a50003", rvalidR, rdataR);
    else passes++;
    checks++; if (ramWeR !== 1'b1 || ramAddrR !== 6'd3 || ramWdataR !== 32'hCAFE0003)
      $display("FAIL rmw_ram: got we=%b addr=%0d data=%h want 1 3 cafe0003", ramWeR, ramAddrR, ramWdataR);
    else passes++;
    nextCycle();
    req = 2'b10; we = 2'b00;
    @(negedge clk);
    checks++; if (gntR !== 2'b10) $display("FAIL rmw_after_gnt_rr: got %b want 10", gntR); else passes++;
    checks++; if (gntF !== 2'b10) $display("FAIL rmw_after_gnt_fp: got %b want 10", gntF); else passes++;
    nextCycle();
    req = 2'b00;
  endtask

  task automatic test_lock_hold;
    doReset();
    req = 2'b01; lock = 2'b01; we = 2'b00; addr = {6'd9, 6'd4};
    @(negedge clk);
    checks++; if (gntR !== 2'b01) $display("FAIL hold_lock_gnt: got %b want 01", gntR); else passes++;
    nextCycle();
    req = 2'b10; lock = 2'b00; addr = {6'd9, 6'd12};
    @(negedge clk);
    checks++; if (gntR !== 2'b00 || gntF !== 2'b00)
      $display("FAIL hold_starve_gnt: got rr=%b fp=%b want 00 00", gntR, gntF);
    else passes++;
    checks++; if (ramEnR !== 1'b0 || ramAddrR !== 6'd4)
      $display("FAIL hold_ram_idle: got en=%b addr=%0d want 0 4", ramEnR, ramAddrR);
    else passes++;
    nextCycle();
    req = 2'b11;
    @(negedge clk);
    checks++; if (gntR !== 2'b01) $display("FAIL hold_unlock_gnt: got %b want 01", gntR); else passes++;
    nextCycle();
    req = 2'b10;
    @(negedge clk);
    checks++; if (gntR !== 2'b10) $display("FAIL hold_release_gnt: got %b want 10", gntR); else passes++;
    nextCycle();
    req = 2'b00;
  endtask

  task automatic test_write_then_read;
    req = 2'b01; lock = 2'b00; we = 2'b01; addr = {6'd0, 6'd7}; wdata = {32'h0, 32'h12345678};
    @(negedge clk);
    checks++; if (gntR !== 2'b01 || ramWeR !== 1'b1)
      $display("FAIL wr_gnt: got gnt=%b we=%b want 01 1", gntR, ramWeR);
    else passes++;
    nextCycle();
    we = 2'b00;
    @(negedge clk);
    checks++; if (rvalidR !== 2'b00) $display("FAIL wr_no_rvalid: got %b want 00", rvalidR); else passes++;
    nextCycle();
    req = 2'b00;
    @(negedge clk);
    checks++; if (rvalidR !== 2'b01 || rdataR !== 32'h12345678)
      $display("FAIL wr_rd_data: got rvalid=%b data=%h want 01 12345678", rvalidR, rdataR);
    else passes++;
    nextCycle();
  endtask

  task automatic test_back_to_back;
    doReset();
    req = 2'b11; we = 2'b00; addr = {6'd11, 6'd10};
    @(negedge clk);
    checks++; if (gntR !== 2'b01) $display("FAIL b2b_gnt0: got %b want 01", gntR); else passes++;
    nextCycle();
    req = 2'b10;
    @(negedge clk);
    checks++; if (gntR !== 2'b10 || rvalidR !== 2'b01 || rdataR !== 32'h00000A0A)
      $display("FAIL b2b_overlap: got gnt=%b rvalid=%b data=%h want 10 01 00000a0a", gntR, rvalidR, rdataR);
    else passes++;
    nextCycle();
    req = 2'b00;
    @(negedge clk);
    checks++; if (rvalidR !== 2'b10 || rdataR !== 32'h00000B0B)
      $display("FAIL b2b_rvalid1: got rvalid=%b data=%h want 10 00000b0b", rvalidR, rdataR);
    else passes++;
    checks++; if (rvalidF !== 2'b10) $display("FAIL b2b_rvalid1_fp: got %b want 10", rvalidF); else passes++;
    nextCycle();
  endtask

  task automatic test_reset_mid_read;
    req = 2'b01; lock = 2'b01; we = 2'b00; addr = {6'd0, 6'd5};
    @(negedge clk);
    checks++; if (gntR !== 2'b01) $display("FAIL midrst_gnt: got %b want 01", gntR); else passes++;
    nextCycle();
    rst = 1'b1; req = 2'b00; lock = 2'b00;
    @(negedge clk);
    checks++; if (rvalidR !== 2'b00) $display("FAIL midrst_rvalid_rst: got %b want 00", rvalidR); else passes++;
    nextCycle();
    rst = 1'b0; req = 2'b11;
    @(negedge clk);
    checks++; if (rvalidR !== 2'b00) $display("FAIL midrst_rvalid_after: got %b want 00", rvalidR); else passes++;
    checks++; if (gntR !== 2'b01) $display("FAIL midrst_ptr_gnt: got %b want 01", gntR); else passes++;
    nextCycle();
    req = 2'b10;
    @(negedge clk);
    checks++; if (gntR !== 2'b10) $display("FAIL midrst_unlocked_gnt: got %b want 10", gntR); else passes++;
    nextCycle();
    req = 2'b00;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      memR[i] = 32'h0;
      memF[i] = 32'h0;
    end
    memR[5]  = 32'hDEADBEEF; memF[5]  = 32'hDEADBEEF;
    memR[3]  = 32'hA5A50003; memF[3]  = 32'hA5A50003;
    memR[10] = 32'h00000A0A; memF[10] = 32'h00000A0A;
    memR[11] = 32'h00000B0B; memF[11] = 32'h00000B0B;
    test_reset();
    test_single_read();
    test_contention();
    test_lock_rmw();
    test_lock_hold();
    test_write_then_read();
    test_back_to_back();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
